// File: rtl/sevenseg_pkg.sv
// Shared constants for the BCD seven-segment display path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (common-anode display).
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit code the calculator uses to flag overflow (on all four digits).
  localparam logic [3:0] OVF_CODE  = 4'b1111;

  // All anodes released (active-low), i.e. display dark.
  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // Blink phase while the latched frame is the overflow code.
  typedef enum logic {
    ON  = 1'b0,
    OFF = 1'b1
  } blink_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment pattern.
// The overflow code maps to a dash; codes 10-14 and a set blank flag map to blank.
module bcd_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup; blank overrides any digit value.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:     seg = SEG_0;
        4'd1:     seg = SEG_1;
        4'd2:     seg = SEG_2;
        4'd3:     seg = SEG_3;
        4'd4:     seg = SEG_4;
        4'd5:     seg = SEG_5;
        4'd6:     seg = SEG_6;
        4'd7:     seg = SEG_7;
        4'd8:     seg = SEG_8;
        4'd9:     seg = SEG_9;
        OVF_CODE: seg = SEG_DASH;
        default:  seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_sevenseg_scanner.sv
// Four-digit time-multiplexed scanner for a common-anode seven-segment display.
// Digits are latched once per scan frame, leading zeros are optionally blanked,
// and an all-overflow frame is shown as a blinking "----".
module bcd_sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 1024,
  parameter int BLINK_FRAMES = 64,
  parameter int LZB_EN       = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  output logic [3:0] An,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic       Ovf
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);

  logic [CNT_W-1:0]  ref_cnt;
  logic [1:0]        idx;
  logic [3:0][3:0]   shadow;
  logic              ovf_q;
  logic [BLK_W-1:0]  blink_cnt;
  blink_state_e      state;
  logic [3:0]        an_q;
  logic [6:0]        seg_q;

  logic              tick;
  logic              frame;
  logic              load_ovf;
  logic [1:0]        next_idx;
  logic [3:0][3:0]   next_shadow;
  logic              next_ovf;
  logic [BLK_W-1:0]  next_blink_cnt;
  blink_state_e      next_state;
  logic              lead_zero;
  logic              cur_blank;
  logic [3:0]        cur_digit;
  logic [6:0]        dec_seg;
  logic [3:0]        an_next;
  logic [6:0]        seg_next;

  assign tick     = (ref_cnt == REF_LAST);
  assign frame    = tick && (idx == 2'd3);
  assign load_ovf = (BCD0 == OVF_CODE) && (BCD1 == OVF_CODE) &&
                    (BCD2 == OVF_CODE) && (BCD3 == OVF_CODE);

  // Values the scan state takes after this edge; outputs are decoded from these
  // so the registered display already matches the new slot on the tick edge.
  always_comb begin
    next_idx    = idx;
    next_shadow = shadow;
    next_ovf    = ovf_q;
    if (tick) begin
      next_idx = idx + 2'd1;
    end
    if (frame) begin
      next_shadow = {BCD3, BCD2, BCD1, BCD0};
      next_ovf    = load_ovf;
    end
  end

  // Slot timer, digit index, per-frame digit snapshot and overflow flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ref_cnt <= '0;
      idx     <= 2'd3;
      shadow  <= {4'd0, 4'd0, 4'd0, 4'd1};
      ovf_q   <= 1'b0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + CNT_W'(1);
      idx     <= next_idx;
      shadow  <= next_shadow;
      ovf_q   <= next_ovf;
    end
  end

  // Blink phase next-state: the counter holds frames spent in the current phase,
  // entering overflow starts a fresh on-phase, and leaving it rearms the blinker.
  always_comb begin
    next_state     = state;
    next_blink_cnt = blink_cnt;
    if (frame) begin
      if (!next_ovf) begin
        next_state     = ON;
        next_blink_cnt = '0;
      end else if (!ovf_q) begin
        next_state     = ON;
        next_blink_cnt = BLK_ONE;
      end else if (blink_cnt == BLK_LAST) begin
        next_blink_cnt = BLK_ONE;
        case (state)
          ON:      next_state = OFF;
          OFF:     next_state = ON;
          default: next_state = ON;
        endcase
      end else begin
        next_blink_cnt = blink_cnt + BLK_ONE;
      end
    end
  end

  // Blink phase state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ON;
      blink_cnt <= '0;
    end else begin
      state     <= next_state;
      blink_cnt <= next_blink_cnt;
    end
  end

  // Leading-zero blanking for the digit about to be shown; digit 0 always shows.
  always_comb begin
    lead_zero = 1'b0;
    case (next_idx)
      2'd3:    lead_zero = (next_shadow[3] == 4'd0);
      2'd2:    lead_zero = (next_shadow[3] == 4'd0) && (next_shadow[2] == 4'd0);
      2'd1:    lead_zero = (next_shadow[3] == 4'd0) && (next_shadow[2] == 4'd0) &&
                           (next_shadow[1] == 4'd0);
      default: lead_zero = 1'b0;
    endcase
    cur_blank = lead_zero && (LZB_EN != 0);
    cur_digit = next_shadow[next_idx];
  end

  bcd_to_seg u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (dec_seg)
  );

  // Anode/segment values for the coming slot; the off blink phase darkens all digits.
  always_comb begin
    an_next  = ~(4'b0001 << next_idx);
    seg_next = dec_seg;
    if (next_ovf && (next_state == OFF)) begin
      an_next  = ANODE_OFF;
      seg_next = SEG_BLANK;
    end
  end

  // Display output registers change only on slot ticks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      an_q  <= ANODE_OFF;
      seg_q <= SEG_BLANK;
    end else if (tick) begin
      an_q  <= an_next;
      seg_q <= seg_next;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Ovf = ovf_q;
  assign Dp  = 1'b1;

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Self-checking bench for bcd_sevenseg_scanner with REFRESH_DIV=4, BLINK_FRAMES=2.
// Two instances share inputs: one with leading-zero blanking, one without.
module tb_bcd_sevenseg_scanner;

  localparam logic [6:0] Z = 7'b1000000;
  localparam logic [6:0] B = 7'b1111111;
  localparam logic [6:0] D = 7'b0111111;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] BCD0 = 4'd0;
  logic [3:0] BCD1 = 4'd0;
  logic [3:0] BCD2 = 4'd0;
  logic [3:0] BCD3 = 4'd0;
  logic [3:0] an_l, an_n;
  logic [6:0] seg_l, seg_n;
  logic       dp_l, dp_n, ovf_l, ovf_n;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nl;
    logic       ovf;
    string      tag;
  } exp_t;

  typedef struct {
    logic [3:0]      b3, b2, b1, b0;
    logic [3:0][6:0] seg;
    logic [3:0][6:0] seg_nl;
    string           tag;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  bcd_sevenseg_scanner #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .LZB_EN(1)) dut (
    .Clk(Clk), .Reset(Reset), .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .An(an_l), .Seg(seg_l), .Dp(dp_l), .Ovf(ovf_l)
  );

  bcd_sevenseg_scanner #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .LZB_EN(0)) dut_nl (
    .Clk(Clk), .Reset(Reset), .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .An(an_n), .Seg(seg_n), .Dp(dp_n), .Ovf(ovf_n)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] anFor(int k);
    case (k)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic vec_t mkVec(string tag, logic [3:0] b3, logic [3:0] b2,
                                 logic [3:0] b1, logic [3:0] b0,
                                 logic [6:0] s3, logic [6:0] s2, logic [6:0] s1, logic [6:0] s0,
                                 logic [6:0] n3, logic [6:0] n2, logic [6:0] n1, logic [6:0] n0);
    vec_t v;
    v.tag = tag;
    v.b3 = b3; v.b2 = b2; v.b1 = b1; v.b0 = b0;
    v.seg    = {s3, s2, s1, s0};
    v.seg_nl = {n3, n2, n1, n0};
    return v;
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic pushExp(logic [3:0] an, logic [6:0] seg, logic [6:0] seg_nl, logic ovf, string tag);
    exp_t e;
    e.an = an; e.seg = seg; e.seg_nl = seg_nl; e.ovf = ovf; e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive one BCD frame and queue the four slots it should produce.
  task automatic applyStimulus(vec_t v);
    BCD3 = v.b3; BCD2 = v.b2; BCD1 = v.b1; BCD0 = v.b0;
    for (int k = 0; k < 4; k++)
      pushExp(anFor(k), v.seg[k], v.seg_nl[k], 1'b0, $sformatf("%s d%0d", v.tag, k));
  endtask

  task automatic applyOverflow();
    BCD3 = 4'hF; BCD2 = 4'hF; BCD1 = 4'hF; BCD0 = 4'hF;
  endtask

  task automatic pushOvfFrame(bit lit, string tag);
    for (int k = 0; k < 4; k++) begin
      if (lit) pushExp(anFor(k), D, D, 1'b1, $sformatf("%s d%0d", tag, k));
      else     pushExp(4'b1111, B, B, 1'b1, $sformatf("%s d%0d", tag, k));
    end
  endtask

  task automatic checkSlot();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.tag, " An"},     {3'b000, an_l}, {3'b000, e.an});
    check({e.tag, " Seg"},    seg_l,          e.seg);
    check({e.tag, " Ovf"},    {6'd0, ovf_l},  {6'd0, e.ovf});
    check({e.tag, " An nl"},  {3'b000, an_n}, {3'b000, e.an});
    check({e.tag, " Seg nl"}, seg_n,          e.seg_nl);
    check({e.tag, " Ovf nl"}, {6'd0, ovf_n},  {6'd0, e.ovf});
  endtask

  // Each slot lasts four cycles; compare just after the slot's tick edge.
  task automatic checkOutput(int n);
    for (int s = 0; s < n; s++) begin
      repeat (4) @(posedge Clk);
      #1;
      checkSlot();
    end
  endtask

  task automatic checkDark(string tag);
    check({tag, " An"},    {3'b000, an_l}, 7'b0001111);
    check({tag, " Seg"},   seg_l,          B);
    check({tag, " Ovf"},   {6'd0, ovf_l},  7'd0);
    check({tag, " Dp"},    {6'd0, dp_l},   7'd1);
    check({tag, " An nl"}, {3'b000, an_n}, 7'b0001111);
    check({tag, " Seg nl"}, seg_n,         B);
  endtask

  // One-cycle reset, then dark for three cycles and lit on the fourth.
  task automatic resetDut();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkDark("reset");
    Reset = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(posedge Clk);
      #1;
      checkDark($sformatf("post-reset c%0d", c));
    end
    @(posedge Clk);
    #1;
    checkSlot();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs.push_back(mkVec("0001", 0, 0, 0, 1,  B, B, B, 7'b1111001,  Z, Z, Z, 7'b1111001));
    vecs.push_back(mkVec("1234", 1, 2, 3, 4,  7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                              7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001));
    vecs.push_back(mkVec("0402", 0, 4, 0, 2,  B, 7'b0011001, Z, 7'b0100100,
                                              Z, 7'b0011001, Z, 7'b0100100));
    vecs.push_back(mkVec("9876", 9, 8, 7, 6,  7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010,
                                              7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010));
    vecs.push_back(mkVec("0050", 0, 0, 5, 0,  B, B, 7'b0010010, Z,  Z, Z, 7'b0010010, Z));
    vecs.push_back(mkVec("0000", 0, 0, 0, 0,  B, B, B, Z,  Z, Z, Z, Z));
    vecs.push_back(mkVec("1000", 1, 0, 0, 0,  7'b1111001, Z, Z, Z,  7'b1111001, Z, Z, Z));
    vecs.push_back(mkVec("3FA0", 3, 15, 10, 0, 7'b0110000, D, B, Z,  7'b0110000, D, B, Z));
    vecs.push_back(mkVec("00C7", 0, 0, 12, 7, B, B, B, 7'b1111000,  Z, Z, B, 7'b1111000));
    vecs.push_back(mkVec("5678", 5, 6, 7, 8,  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
                                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000));
    vecs.push_back(mkVec("0009", 0, 0, 0, 9,  B, B, B, 7'b0010000,  Z, Z, Z, 7'b0010000));

    // Reset with 0,0,0,1 held: dark for four cycles, then the first frame.
    applyStimulus(vecs[0]);
    resetDut();
    checkOutput(3);

    // Table of frames, each loaded at the next frame boundary.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(4);
    end

    // Inputs changed while digit 1 is showing stay invisible until the next frame.
    applyStimulus(vecs[1]);
    checkOutput(2);
    applyStimulus(vecs[9]);
    checkOutput(6);

    // Overflow blink: on, on, off, off, on, on, off; then exit from an off frame.
    applyOverflow();
    pushOvfFrame(1'b1, "ovf f1");
    pushOvfFrame(1'b1, "ovf f2");
    pushOvfFrame(1'b0, "ovf f3");
    pushOvfFrame(1'b0, "ovf f4");
    pushOvfFrame(1'b1, "ovf f5");
    pushOvfFrame(1'b1, "ovf f6");
    pushOvfFrame(1'b0, "ovf f7");
    checkOutput(28);
    applyStimulus(vecs[10]);
    checkOutput(4);

    // Re-entering overflow restarts the blink sequence in the on phase.
    applyOverflow();
    pushOvfFrame(1'b1, "reovf f1");
    pushOvfFrame(1'b1, "reovf f2");
    pushOvfFrame(1'b0, "reovf f3");
    pushOvfFrame(1'b0, "reovf f4");
    pushOvfFrame(1'b1, "reovf f5");
    checkOutput(19);

    // Reset while digit 2 is lit during overflow; fresh inputs appear after restart.
    sb.delete();
    applyStimulus(vecs[3]);
    resetDut();
    checkOutput(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
